// File: rtl/q_capture_ctrl.sv
// Q-flop sample controller: strobes q_clock, waits for the synchronized ack
// handshake, and queues each resolved value into a 4-entry FIFO.
module q_capture_ctrl #(
    parameter int TIMEOUT   = 12,
    parameter int TIMEOUT_W = 4
) (
    input  logic       clock,
    input  logic       reset_l,
    input  logic       start,
    output logic       q_clock,
    input  logic       q_ack,
    input  logic       q_out,
    output logic       dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic [2:0] fifo_count,
    output logic       busy,
    output logic       timeout_err,
    input  logic       clear_err
);

    typedef enum logic [2:0] {IDLE, ARM, CAPTURE, RELEASE, ERR} state_t;

    state_t                 state, state_nxt;
    logic [1:0]             ack_sync, out_sync;
    logic                   ack_s, out_s;
    logic [TIMEOUT_W-1:0]   wait_cnt;
    logic                   wait_hit;
    logic [3:0]             mem;
    logic [1:0]             wr_ptr, rd_ptr;
    logic                   push, pop;

    // q_ack/q_out come from a possibly metastable flop; only the synced copies are used
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            ack_sync <= '0;
            out_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[0], q_ack};
            out_sync <= {out_sync[0], q_out};
        end
    end

    assign ack_s = ack_sync[1];
    assign out_s = out_sync[1];

    // Wait counter reads 0 in the first cycle of a state, so hitting TIMEOUT-1
    // means TIMEOUT cycles have been spent waiting.
    assign wait_hit = (wait_cnt == TIMEOUT_W'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && fifo_count != 3'd4) state_nxt = ARM;
            ARM:     if (ack_s) state_nxt = CAPTURE;
                     else if (wait_hit) state_nxt = ERR;
            CAPTURE: state_nxt = RELEASE;
            RELEASE: if (!ack_s) state_nxt = IDLE;
                     else if (wait_hit) state_nxt = ERR;
            ERR:     if (clear_err) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != IDLE);
        timeout_err = (state == ERR);
        push        = (state == CAPTURE);
    end

    // q_clock is registered from the next state so it is a clean flop output
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            q_clock <= 1'b0;
        end else begin
            q_clock <= (state_nxt == ARM);
        end
    end

    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            wait_cnt <= '0;
        end else if (state_nxt != state) begin
            wait_cnt <= '0;
        end else if ((state == ARM || state == RELEASE) &&
                     wait_cnt != TIMEOUT_W'(TIMEOUT)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign dout_valid = (fifo_count != 3'd0);
    assign dout       = mem[rd_ptr];
    assign pop        = dout_valid && dout_ready;

    // Overflow cannot occur: a start is only accepted with a free slot
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            mem        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= out_s;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule
